// File: rtl/mssb_uart_rx_pkg.sv
// Shared types and constants for the MSSB serial receive path.
package mssb_pkg;

  localparam int RX_COUNT_W = 20;
  localparam int BYTE_W     = 8;
  localparam int CNT_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/mssb_uart_rx_bit_timer.sv
// Sync chain, falling-edge detect and bit-centre timing for the MSSB receiver.
// MSSB_RX_MAJORITY_EN: decisions become a 2-of-3 vote around the centre, taken one count later.
module mssb_bit_timer
  import mssb_pkg::*;
#(
  parameter int CLKS_PER_BIT = 108,
  parameter int SYNC_STAGES  = 2
) (
  input  logic OPB_CLK,
  input  logic OPB_RST,
  input  logic MSSB_RX,
  input  logic half_sel,
  input  logic cnt_clr,
  input  logic cnt_adv,
  output logic rx_s,
  output logic start_edge,
  output logic sample_tick,
  output logic bit_val
);

  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_C = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_d;
  logic [CNT_W-1:0]       bit_cnt;
  logic [CNT_W-1:0]       centre;

  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      sync_q <= '1;
      rx_d   <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], MSSB_RX};
      rx_d   <= rx_s;
    end
  end

  assign rx_s       = sync_q[SYNC_STAGES-1];
  assign start_edge = rx_d & ~rx_s;
  assign centre     = half_sel ? HALF_C : FULL_C;

`ifdef MSSB_RX_MAJORITY_EN
  // Advancing one count late, so reload 1 to keep later centres on the bit grid.
  localparam logic [CNT_W-1:0] ADV_LOAD = CNT_W'(1);

  logic s_m1;
  logic s_c;

  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      s_m1 <= 1'b1;
      s_c  <= 1'b1;
    end else begin
      if (bit_cnt == centre - CNT_W'(1)) s_m1 <= rx_s;
      if (bit_cnt == centre)             s_c  <= rx_s;
    end
  end

  assign sample_tick = (bit_cnt == centre + CNT_W'(1));
  assign bit_val     = (s_m1 & s_c) | (s_m1 & rx_s) | (s_c & rx_s);
`else
  localparam logic [CNT_W-1:0] ADV_LOAD = '0;

  assign sample_tick = (bit_cnt == centre);
  assign bit_val     = rx_s;
`endif

  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST)      bit_cnt <= '0;
    else if (cnt_clr) bit_cnt <= '0;
    else if (cnt_adv) bit_cnt <= ADV_LOAD;
    else              bit_cnt <= bit_cnt + CNT_W'(1);
  end

endmodule

// File: rtl/mssb_uart_rx.sv
// MSSB 8N1 receive front end with strobe/acknowledge byte output and diagnostics.
// Optional MSSB_RX_MAJORITY_EN selects majority-vote sampling in mssb_bit_timer.
//
// state    | meaning
// IDLE     | line idle, waiting for a falling edge
// START    | timing to start-bit centre, rejecting glitches
// DATA     | sampling 8 data bits, LSB first
// STOP     | sampling the stop bit, then deliver or flag framing error
// BREAK    | line held low after a framing error, wait for it to return high
module mssb_uart_rx
  import mssb_pkg::*;
#(
  parameter int BAUD_RATE       = 921600,
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                  OPB_CLK,
  input  logic                  OPB_RST,
  input  logic                  MSSB_RX,
  output logic [BYTE_W-1:0]     DATA_OUT,
  output logic                  DATA_OUT_STB,
  input  logic                  DATA_OUT_ACK,
  output logic                  FRAME_ERR,
  output logic                  OVERRUN,
  output logic [RX_COUNT_W-1:0] RX_COUNT,
  output logic                  RX_BUSY
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);

  rx_state_t         state_q;
  rx_state_t         state_d;
  logic              rx_s;
  logic              start_edge;
  logic              sample_tick;
  logic              bit_val;
  logic              half_sel;
  logic              cnt_clr;
  logic              cnt_adv;
  logic              shift_en;
  logic              deliver;
  logic              frame_err_set;
  logic [2:0]        bit_idx_q;
  logic [BYTE_W-1:0] shift_q;

  mssb_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .SYNC_STAGES  (SYNC_STAGES)
  ) u_bit_timer (
    .OPB_CLK     (OPB_CLK),
    .OPB_RST     (OPB_RST),
    .MSSB_RX     (MSSB_RX),
    .half_sel    (half_sel),
    .cnt_clr     (cnt_clr),
    .cnt_adv     (cnt_adv),
    .rx_s        (rx_s),
    .start_edge  (start_edge),
    .sample_tick (sample_tick),
    .bit_val     (bit_val)
  );

  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    half_sel      = 1'b0;
    cnt_clr       = 1'b0;
    cnt_adv       = 1'b0;
    shift_en      = 1'b0;
    deliver       = 1'b0;
    frame_err_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (start_edge) state_d = ST_START;
      end
      ST_START: begin
        half_sel = 1'b1;
        if (sample_tick) begin
          if (!bit_val) begin
            cnt_adv = 1'b1;
            state_d = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (sample_tick) begin
          shift_en = 1'b1;
          cnt_adv  = 1'b1;
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (sample_tick) begin
          cnt_adv = 1'b1;
          if (bit_val) begin
            deliver = 1'b1;
            state_d = ST_IDLE;
          end else begin
            frame_err_set = 1'b1;
            state_d       = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        cnt_clr = 1'b1;
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      if (state_q != ST_DATA) bit_idx_q <= '0;
      else if (shift_en)      bit_idx_q <= bit_idx_q + 3'd1;
      if (shift_en) shift_q <= {bit_val, shift_q[BYTE_W-1:1]};
    end
  end

  // An ACK on the delivery edge frees the slot, so the new byte loads without overrun.
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      DATA_OUT     <= '0;
      DATA_OUT_STB <= 1'b0;
      RX_COUNT     <= '0;
      FRAME_ERR    <= 1'b0;
      OVERRUN      <= 1'b0;
    end else begin
      FRAME_ERR <= frame_err_set;
      OVERRUN   <= deliver & DATA_OUT_STB & ~DATA_OUT_ACK;
      if (deliver && (!DATA_OUT_STB || DATA_OUT_ACK)) begin
        DATA_OUT     <= shift_q;
        DATA_OUT_STB <= 1'b1;
        RX_COUNT     <= RX_COUNT + RX_COUNT_W'(1);
      end else if (DATA_OUT_STB && DATA_OUT_ACK) begin
        DATA_OUT_STB <= 1'b0;
      end
    end
  end

  assign RX_BUSY = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mssb_uart_rx.sv
// Directed bench for mssb_uart_rx; expected bytes are queued at send time and popped on each STB rise.
// Runs the DUT at a faster line rate so the 512-byte sweep stays short; timing expectations scale with it.
`timescale 1ns/1ps
module tb_mssb_uart_rx;

  localparam int CLK_HZ = 100_000_000;
  localparam int BAUD   = 11_000_000;
  localparam int SYNC   = 2;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int HALF   = CPB / 2;
`ifdef MSSB_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  localparam int LAT       = SYNC + 1 + HALF + 9 * CPB + MAJ;
  localparam int BUSY_DROP = SYNC + 1 + HALF + MAJ;
  localparam int GL_LEN    = 2;

  logic        OPB_CLK = 1'b0;
  logic        OPB_RST;
  logic        MSSB_RX;
  logic [7:0]  DATA_OUT;
  logic        DATA_OUT_STB;
  logic        DATA_OUT_ACK;
  logic        FRAME_ERR;
  logic        OVERRUN;
  logic [19:0] RX_COUNT;
  logic        RX_BUSY;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rises = 0;
  int stb_run = 0;
  int last_stb_len = 0;
  int fe_cyc = 0;
  int ov_cnt = 0;
  int ov_cyc = 0;
  int rise_cyc = 0;
  int fall_cyc = 0;
  logic stb_prev = 1'b0;
  logic ack_en = 1'b1;
  logic [7:0] exp_b;
  logic [7:0] exp_q[$];

  mssb_uart_rx #(
    .BAUD_RATE       (BAUD),
    .CLOCK_FREQUENCY (CLK_HZ),
    .SYNC_STAGES     (SYNC)
  ) dut (
    .OPB_CLK      (OPB_CLK),
    .OPB_RST      (OPB_RST),
    .MSSB_RX      (MSSB_RX),
    .DATA_OUT     (DATA_OUT),
    .DATA_OUT_STB (DATA_OUT_STB),
    .DATA_OUT_ACK (DATA_OUT_ACK),
    .FRAME_ERR    (FRAME_ERR),
    .OVERRUN      (OVERRUN),
    .RX_COUNT     (RX_COUNT),
    .RX_BUSY      (RX_BUSY)
  );

  always #5 OPB_CLK = ~OPB_CLK;
  always @(posedge OPB_CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Consumer registers ACK from STB; also the output monitor and scoreboard pop.
  always @(negedge OPB_CLK) begin
    DATA_OUT_ACK = ack_en && stb_prev;
    if (DATA_OUT_STB && !stb_prev) begin
      rises++;
      rise_cyc = cyc;
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_stb: observed byte %0h expected no delivery", DATA_OUT);
      end
      if (exp_q.size() != 0) begin
        exp_b = exp_q.pop_front();
        check("data_out", 32'(DATA_OUT), 32'(exp_b));
      end
    end
    if (DATA_OUT_STB) stb_run++;
    else begin
      if (stb_prev) last_stb_len = stb_run;
      stb_run = 0;
    end
    if (FRAME_ERR) fe_cyc++;
    if (OVERRUN) begin
      ov_cnt++;
      ov_cyc = cyc;
    end
    stb_prev = DATA_OUT_STB;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge OPB_CLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic spike);
    for (int i = 0; i < 10; i++) begin
      logic b;
      b = (i == 0) ? 1'b0 : (i == 9) ? stop : d[i-1];
      MSSB_RX = b;
      if (i == 0) fall_cyc = cyc;
      if (spike) begin
        idle(HALF);
        MSSB_RX = ~b;
        idle(1);
        MSSB_RX = b;
        idle(CPB - HALF - 1);
      end else begin
        idle(CPB);
      end
    end
  endtask

  task automatic pulse_reset();
    OPB_RST = 1'b1;
    MSSB_RX = 1'b1;
    idle(3);
    OPB_RST = 1'b0;
    idle(3);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_data"},  32'(DATA_OUT), 32'h0);
    check({tag, "_stb"},   32'(DATA_OUT_STB), 32'h0);
    check({tag, "_ferr"},  32'(FRAME_ERR), 32'h0);
    check({tag, "_ovr"},   32'(OVERRUN), 32'h0);
    check({tag, "_count"}, 32'(RX_COUNT), 32'h0);
    check({tag, "_busy"},  32'(RX_BUSY), 32'h0);
  endtask

  initial begin
    int r0;
    int fe0;
    int ov0;
    int fall2;
    OPB_RST      = 1'b1;
    MSSB_RX      = 1'b1;
    DATA_OUT_ACK = 1'b0;
    idle(3);
    check_reset_vals("reset");
    OPB_RST = 1'b0;
    idle(5);

    // Single frame, registered ACK
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(20);
    check("a5_latency", 32'(rise_cyc - fall_cyc), 32'(LAT));
    check("a5_stb_len", 32'(last_stb_len), 32'd2);
    check("a5_count", 32'(RX_COUNT), 32'd1);
    check("a5_data_hold", 32'(DATA_OUT), 32'hA5);

    // Start-bit glitch
    r0 = rises;
    MSSB_RX = 1'b0;
    idle(GL_LEN);
    MSSB_RX = 1'b1;
    idle(BUSY_DROP - 1 - GL_LEN);
    check("glitch_busy_hi", 32'(RX_BUSY), 32'd1);
    idle(1);
    check("glitch_busy_lo", 32'(RX_BUSY), 32'd0);
    idle(10);
    check("glitch_no_stb", 32'(rises), 32'(r0));
    check("glitch_no_ferr", 32'(fe_cyc), 32'd0);

    // Framing error then line held low
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(500);
    check("ferr_pulse", 32'(fe_cyc), 32'd1);
    check("ferr_no_stb", 32'(rises), 32'(r0));
    check("ferr_break_busy", 32'(RX_BUSY), 32'd1);
    MSSB_RX = 1'b1;
    idle(10);
    check("ferr_break_exit", 32'(RX_BUSY), 32'd0);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 1'b0);
    idle(20);
    check("ferr_count", 32'(RX_COUNT), 32'd2);

    // Overrun with ACK withheld
    pulse_reset();
    ack_en = 1'b0;
    ov0 = ov_cnt;
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1, 1'b0);
    send_frame(8'h02, 1'b1, 1'b0);
    fall2 = fall_cyc;
    idle(20);
    check("ovr_pulses", 32'(ov_cnt - ov0), 32'd1);
    check("ovr_timing", 32'(ov_cyc - fall2), 32'(LAT));
    check("ovr_data", 32'(DATA_OUT), 32'h01);
    check("ovr_stb", 32'(DATA_OUT_STB), 32'd1);
    check("ovr_count", 32'(RX_COUNT), 32'd1);
    ack_en = 1'b1;
    idle(4);
    check("ovr_ack_stb", 32'(DATA_OUT_STB), 32'd0);
    check("ovr_ack_hold", 32'(DATA_OUT), 32'h01);

    // 512-byte sweep
    pulse_reset();
    fe0 = fe_cyc;
    ov0 = ov_cnt;
    for (int k = 0; k < 512; k++) begin
      logic [7:0] kb;
      kb = 8'(k);
      exp_q.push_back(kb);
      send_frame(kb, 1'b1, 1'b0);
    end
    idle(20);
    check("sweep_count", 32'(RX_COUNT), 32'd512);
    check("sweep_ferr", 32'(fe_cyc - fe0), 32'd0);
    check("sweep_ovr", 32'(ov_cnt - ov0), 32'd0);
    check("sweep_last", 32'(DATA_OUT), 32'hFF);

    // Reset mid-frame
    r0 = rises;
    MSSB_RX = 1'b0;
    idle(CPB);
    MSSB_RX = 1'b1;
    idle(CPB);
    MSSB_RX = 1'b0;
    idle(HALF);
    OPB_RST = 1'b1;
    idle(1);
    check_reset_vals("midrst");
    MSSB_RX = 1'b1;
    idle(2);
    OPB_RST = 1'b0;
    idle(12 * CPB);
    check("midrst_idle", 32'(RX_BUSY), 32'd0);
    check("midrst_no_stb", 32'(rises), 32'(r0));
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 1'b0);
    idle(20);
    check("midrst_count", 32'(RX_COUNT), 32'd1);

`ifdef MSSB_RX_MAJORITY_EN
    // Single-cycle spikes at every bit centre
    r0 = rises;
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1, 1'b1);
    idle(20);
    check("maj_delivered", 32'(rises - r0), 32'd1);
    check("maj_latency", 32'(rise_cyc - fall_cyc), 32'(LAT));
    check("maj_count", 32'(RX_COUNT), 32'd2);
`endif

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
